// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and limits for the multiplier-sharing arbiter.
// Pure declarations: no latency, no flow control.
package mul_arb_pkg;
  typedef logic signed [15:0] sample_t;
  localparam int MUL_FRAC_W = 16;
  localparam int N_REQ_MAX  = 8;
endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between effect stages and the shared multiplier.
// Requests use valid/ready; responses are valid-only and cannot be stalled.
interface mul_share_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        rsp_valid;
  logic signed [DATA_W-1:0] rsp_data;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/mul_share_arbiter_rr_picker.sv
// Round-robin priority select: first asserted request at or after ptr, wrapping.
// Combinational; no flow control of its own.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);
  int   j;
  logic found;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    j            = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found           = 1'b1;
        grant_onehot[j] = 1'b1;
        grant_idx       = IDX_W'(j);
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/multiply.sv
// Q-format multiply: y = (a*b)/2^16 truncated toward zero, never saturated.
// Purely combinational; no flow control.
module multiply (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [15:0] y
);
  logic signed [31:0] p;
  logic signed [31:0] biased;

  assign p = a * b;
  // Bias negative products so the arithmetic shift truncates toward zero, not floor.
  assign biased = p + (p[31] ? 32'sd65535 : 32'sd0);
  assign y = 16'(biased >>> 16);
endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin shares one Q-format multiplier among N_REQ requesters, one accept per cycle.
// Result valid the cycle after the edge following accept; the pipeline never stalls.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic rst,
  mul_share_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);

  if (DATA_W != $bits(sample_t)) begin : g_bad_width
    $error("mul_share_arbiter: DATA_W must be 16");
  end
  if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_nreq
    $error("mul_share_arbiter: N_REQ must be 2..8");
  end

  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0] grant_idx;
  logic             any;
  logic             accept;

  sample_t          sel_a, sel_b;
  logic             s1_valid;
  sample_t          s1_a, s1_b;
  logic [N_REQ-1:0] s1_tag;
  sample_t          product;
  logic             s2_valid;
  sample_t          s2_data;
  logic [N_REQ-1:0] s2_tag;

  rr_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req          (bus.req_valid),
    .ptr          (ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any)
  );

  // Grant is always the accept, since the winner is by construction valid.
  assign bus.req_ready = rst ? '0 : grant_onehot;
  assign accept        = any & ~rst;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_a = sample_t'(bus.req_a[i*DATA_W +: DATA_W]);
        sel_b = sample_t'(bus.req_b[i*DATA_W +: DATA_W]);
      end
    end
  end

  multiply u_mul (
    .a (s1_a),
    .b (s1_b),
    .y (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= sel_a;
        s1_b   <= sel_b;
        s1_tag <= grant_onehot;
        ptr    <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      s2_valid <= s1_valid;
      // Result register only moves on a real product so rsp_data holds between results.
      if (s1_valid) begin
        s2_data <= product;
        s2_tag  <= s1_tag;
      end
    end
  end

  assign bus.rsp_valid = s2_valid ? s2_tag : '0;
  assign bus.rsp_data  = s2_data;
  assign bus.busy      = s1_valid | s2_valid;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench: arithmetic vector table plus hand-written arbitration/reset sequences.
module tb_mul_share_arbiter;
  import mul_arb_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mul_share_arbiter_if #(.N_REQ(4), .DATA_W(16)) bus ();

  mul_share_arbiter #(.N_REQ(4), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int      r;
    sample_t a;
    sample_t b;
    sample_t exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input sample_t a, input sample_t b);
    bus.req_a[r*16 +: 16] = a;
    bus.req_b[r*16 +: 16] = b;
  endtask

  // With every requester valid the winner equals the pointer; drop valid before the edge.
  task automatic probe_ptr(input string name, input int exp_ptr);
    bus.req_valid = 4'b1111;
    #1;
    chk(name, 32'(bus.req_ready), 32'(1) << exp_ptr);
    bus.req_valid = 4'b0000;
    #1;
  endtask

  initial begin
    vecs[0] = '{0,  16384,  16384,   4096};
    vecs[1] = '{1,     -1,      1,      0};
    vecs[2] = '{2,     -3,  30000,     -1};
    vecs[3] = '{3, -32768, -32768,  16384};
    vecs[4] = '{0,  32767, -32768, -16383};
    vecs[5] = '{1,  32767,  32767,  16383};
    vecs[6] = '{2, -32768,      2,     -1};
    vecs[7] = '{3, -32768,      1,      0};
    vecs[8] = '{0,    100,   -100,      0};
    vecs[9] = '{1,   -300,   -300,      1};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    step();
    step();

    // Reset state
    bus.req_valid = 4'b1111;
    #1;
    chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    #1;
    probe_ptr("rst_ptr", 0);

    // Arithmetic table, one lone requester at a time
    for (int v = 0; v < 10; v++) begin
      set_req(vecs[v].r, vecs[v].a, vecs[v].b);
      bus.req_valid = 4'b0001 << vecs[v].r;
      #1;
      chk($sformatf("vec%0d_ready", v), 32'(bus.req_ready), 32'(1) << vecs[v].r);
      step();
      bus.req_valid = '0;
      chk($sformatf("vec%0d_mid_rsp_valid", v), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("vec%0d_mid_busy", v), 32'(bus.busy), 32'd1);
      step();
      chk($sformatf("vec%0d_rsp_valid", v), 32'(bus.rsp_valid), 32'(1) << vecs[v].r);
      chk($sformatf("vec%0d_rsp_data", v), 32'(bus.rsp_data), 32'(vecs[v].exp));
      step();
      chk($sformatf("vec%0d_idle_rsp_valid", v), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("vec%0d_hold_data", v), 32'(bus.rsp_data), 32'(vecs[v].exp));
      chk($sformatf("vec%0d_idle_busy", v), 32'(bus.busy), 32'd0);
    end

    // All four valid for 8 cycles: strict rotation, results one per cycle in order
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, sample_t'(i + 1), 16'sd16384);
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        bus.req_valid = 4'b1111;
        #1;
        chk($sformatf("rot%0d_grant", c), 32'(bus.req_ready), 32'(1) << (c % 4));
      end else begin
        bus.req_valid = '0;
      end
      if (c >= 2) begin
        chk($sformatf("rot%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'(1) << ((c - 2) % 4));
        chk($sformatf("rot%0d_rsp_data", c), 32'(bus.rsp_data), 32'((((c - 2) % 4) + 1) / 4));
      end else if (c == 1) begin
        chk("rot1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
      step();
    end
    bus.req_valid = '0;
    step();

    // Pointer at 2 with only req0 and req3 valid: 3 first, then 0, ptr ends at 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b1001;
    #1;
    chk("ptr2_first_grant", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid = 4'b0001;
    #1;
    chk("ptr2_second_grant", 32'(bus.req_ready), 32'b0001);
    step();
    probe_ptr("ptr_after_wrap", 1);

    // Idle after traffic: no grants, busy drains in two cycles, pointer holds
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("idle%0d_ready", j), 32'(bus.req_ready), 32'd0);
      chk($sformatf("idle%0d_busy", j), 32'(bus.busy), (j < 2) ? 32'd1 : 32'd0);
      step();
    end
    probe_ptr("idle_ptr_held", 1);

    // Accept then reset on the next edge: in-flight entry discarded
    set_req(2, 16'sd16384, 16'sd16384);
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_rsp_data", 32'(bus.rsp_data), 32'd0);
    step();
    chk("flush_rsp_valid_late", 32'(bus.rsp_valid), 32'd0);
    probe_ptr("flush_ptr", 0);

    // Reset while a response is presented: outputs zero on the next cycle
    set_req(1, 16'sd16384, 16'sd16384);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    step();
    chk("rsp_before_rst", 32'(bus.rsp_valid), 32'b0010);
    rst = 1'b1;
    step();
    chk("rsp_valid_after_rst", 32'(bus.rsp_valid), 32'd0);
    chk("rsp_data_after_rst", 32'(bus.rsp_data), 32'd0);
    chk("busy_after_rst", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
